// File: rtl/msk_and_hpc3_pipe_pkg.sv
// Shared constants and index helpers for the HPC3 masked-AND pipeline.
// Randomness layout per lane: r block then r' block, pairs (i<j) in row-major order.
package msk_hpc3_pkg;

    localparam int STARVE_W = 16;

    // Fresh random bits one lane consumes per transfer (r and r' blocks together).
    function automatic int hpc3_rnd(input int d);
        return d * (d - 1);
    endfunction

    // Row-major index of pair (i,j), i<j, within one d*(d-1)/2 block.
    function automatic int pair_idx(input int i, input int j, input int d);
        return i * d - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/msk_and_hpc3_pipe_if.sv
// Valid/ready bus for the HPC3 masked-AND pipeline: operand sharings, randomness and result.
interface msk_and_hpc3_pipe_if #(
    parameter int d = 2,
    parameter int W = 1
) ();
    import msk_hpc3_pkg::*;

    localparam int NRND = W * hpc3_rnd(d);

    logic [W*d-1:0]  ina;
    logic [W*d-1:0]  inb;
    logic            in_valid;
    logic            in_ready;
    logic [NRND-1:0] rnd;
    logic            rnd_valid;
    logic            rnd_ready;
    logic [W*d-1:0]  out;
    logic            out_valid;
    logic            out_ready;

    modport master (
        output ina, inb, in_valid, rnd, rnd_valid, out_ready,
        input  in_ready, rnd_ready, out, out_valid
    );

    modport slave (
        input  ina, inb, in_valid, rnd, rnd_valid, out_ready,
        output in_ready, rnd_ready, out, out_valid
    );

endinterface

// File: rtl/msk_and_hpc3_pipe_lane.sv
// One lane of the HPC3 masked AND: cross-domain terms registered on enable, XOR after the registers.
// MSKAND_HPC3_PIPE_INNER_EN adds the registered inner-domain term a_i&b_i to each output share.
module msk_hpc3_lane import msk_hpc3_pkg::*; #(
    parameter int d = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [d-1:0]           a,
    input  logic [d-1:0]           b,
    input  logic [hpc3_rnd(d)-1:0] rnd,
    output logic [d-1:0]           c
);

    localparam int NPAIR = hpc3_rnd(d) / 2;

    logic [d-1:0][d-1:0] x_d, y_d, x_q, y_q;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        int   idx;
        logic r, rp;
        x_d = '0;
        y_d = '0;
        idx = 0;
        r   = 1'b0;
        rp  = 1'b0;
        for (int i = 0; i < d; i++) begin
            for (int j = 0; j < d; j++) begin
                if (i != j) begin
                    idx = (i < j) ? pair_idx(i, j, d) : pair_idx(j, i, d);
                    r   = rnd[idx];
                    rp  = rnd[NPAIR + idx];
                    x_d[i][j] = (a[i] & (b[j] ^ r)) ^ rp;
                    y_d[i][j] = (~a[i] & r) ^ rp;
                end
            end
        end
    end

    // NOTE: all share registers are reset so no stale mask survives a reset.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else if (en) begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    logic [d-1:0] base;

`ifdef MSKAND_HPC3_PIPE_INNER_EN
    logic [d-1:0] inner_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inner_q <= '0;
        end else if (en) begin
            inner_q <= a & b;
        end
    end

    assign base = inner_q;
`else
    assign base = '0;
`endif

    // Share compression happens only on registered values.
    always_comb begin
        c = base;
        for (int i = 0; i < d; i++) begin
            for (int j = 0; j < d; j++) begin
                if (i != j) begin
                    c[i] = c[i] ^ x_q[i][j] ^ y_q[i][j];
                end
            end
        end
    end

endmodule

// File: rtl/msk_and_hpc3_pipe.sv
// W-lane, d-share HPC3 masked AND with valid/ready flow control and randomness handshake.
// Build with MSKAND_HPC3_PIPE_INNER_EN for full HPC3 (out = a&b); default is cross terms only.
module msk_and_hpc3_pipe import msk_hpc3_pkg::*; #(
    parameter int d = 2,
    parameter int W = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    msk_and_hpc3_pipe_if.slave  bus,
    output logic [STARVE_W-1:0] starve_cnt
);

    localparam int LRND = hpc3_rnd(d);

    logic           in_ready;
    logic           xfer;
    logic           out_valid_q;
    logic [W*d-1:0] out_c;

    // A new operand is taken only with fresh randomness and a free (or draining) output slot.
    assign in_ready      = bus.rnd_valid & (~out_valid_q | bus.out_ready);
    assign xfer          = bus.in_valid & in_ready;
    assign bus.in_ready  = in_ready;
    assign bus.rnd_ready = xfer;
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (bus.in_valid && !bus.rnd_valid && starve_cnt != '1) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    for (genvar k = 0; k < W; k++) begin : g_lane
        msk_hpc3_lane #(.d(d)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (xfer),
            .a     (bus.ina[k*d +: d]),
            .b     (bus.inb[k*d +: d]),
            .rnd   (bus.rnd[k*LRND +: LRND]),
            .c     (out_c[k*d +: d])
        );
    end

endmodule

// File: tb/tb_msk_and_hpc3_pipe.sv
// Scoreboard bench for msk_and_hpc3_pipe (d=3, W=2); expectations follow the build's
// MSKAND_HPC3_PIPE_INNER_EN setting.
module tb_msk_and_hpc3_pipe;

    localparam int D  = 3;
    localparam int W  = 2;
    localparam int LR = D * (D - 1);
    localparam int NR = W * LR;
    localparam int WD = W * D;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] starve_cnt;

    always #5 clk = ~clk;

    msk_and_hpc3_pipe_if #(.d(D), .W(W)) bus ();

    msk_and_hpc3_pipe #(.d(D), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .starve_cnt (starve_cnt)
    );

    typedef struct {
        logic [WD-1:0] out;
        logic [W-1:0]  par;
    } exp_t;

    typedef struct {
        logic [WD-1:0] a;
        logic [WD-1:0] b;
        logic [NR-1:0] r;
    } vec_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pair numbering by enumeration, independent of any closed form.
    function automatic int pidx(input int i, input int j);
        int n   = 0;
        int res = 0;
        for (int p = 0; p < D; p++) begin
            for (int q = p + 1; q < D; q++) begin
                if (p == i && q == j) res = n;
                n++;
            end
        end
        return res;
    endfunction

    // Share-exact model: x^y collapses to a_i&b_j ^ r_ij; r' cancels inside each share.
    function automatic logic [WD-1:0] model_out(input logic [WD-1:0] a, input logic [WD-1:0] b,
                                                input logic [NR-1:0] r);
        logic [WD-1:0] c;
        c = '0;
        for (int k = 0; k < W; k++) begin
            for (int i = 0; i < D; i++) begin
`ifdef MSKAND_HPC3_PIPE_INNER_EN
                c[k*D+i] = a[k*D+i] & b[k*D+i];
`endif
                for (int j = 0; j < D; j++) begin
                    if (i != j) begin
                        c[k*D+i] = c[k*D+i] ^ (a[k*D+i] & b[k*D+j])
                                   ^ r[k*LR + ((i < j) ? pidx(i, j) : pidx(j, i))];
                    end
                end
            end
        end
        return c;
    endfunction

    // Unmasked per-lane value derived from operand parities.
    function automatic logic [W-1:0] model_par(input logic [WD-1:0] a, input logic [WD-1:0] b);
        logic [W-1:0] p;
        logic pa, pb, inner;
        for (int k = 0; k < W; k++) begin
            pa = 1'b0;
            pb = 1'b0;
            inner = 1'b0;
            for (int i = 0; i < D; i++) begin
                pa    = pa ^ a[k*D+i];
                pb    = pb ^ b[k*D+i];
                inner = inner ^ (a[k*D+i] & b[k*D+i]);
            end
`ifdef MSKAND_HPC3_PIPE_INNER_EN
            p[k] = pa & pb;
`else
            p[k] = (pa & pb) ^ inner;
`endif
        end
        return p;
    endfunction

    function automatic logic [W-1:0] lane_par(input logic [WD-1:0] v);
        logic [W-1:0] p;
        p = '0;
        for (int k = 0; k < W; k++) begin
            for (int i = 0; i < D; i++) p[k] = p[k] ^ v[k*D+i];
        end
        return p;
    endfunction

    // Monitor: a transfer seen at one negedge must show up as a result at the next.
    logic pend = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_underflow: result %0h with no expectation queued", bus.out);
                end else begin
                    e = sb.pop_front();
                    check("mon_out_valid", 64'(bus.out_valid), 64'(1'b1));
                    check("mon_out_shares", 64'(bus.out), 64'(e.out));
                    check("mon_lane_xor", 64'(lane_par(bus.out)), 64'(e.par));
                end
            end
            pend = bus.in_valid & bus.in_ready;
        end
    end

    // Present one operand pair; wait (bounded) for acceptance, queue the expectation.
    task automatic send(input vec_t v);
        int waited = 0;
        bus.ina      = v.a;
        bus.inb      = v.b;
        bus.rnd      = v.r;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        check("send_accept", 64'(bus.in_ready), 64'(1'b1));
        if (bus.in_ready) sb.push_back('{out: model_out(v.a, v.b, v.r), par: model_par(v.a, v.b)});
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[8];
    logic [WD-1:0] held;

    initial begin
        vecs[0] = '{a: 6'h00, b: 6'h00, r: 12'h000};
        vecs[1] = '{a: 6'h3F, b: 6'h3F, r: 12'hFFF};
        vecs[2] = '{a: 6'b000_001, b: 6'b000_001, r: 12'h000};
        vecs[3] = '{a: 6'b010_001, b: 6'b100_010, r: 12'h5A5};
        vecs[4] = '{a: 6'h2A, b: 6'h15, r: 12'hC3C};
        vecs[5] = '{a: 6'h15, b: 6'h15, r: 12'h0F0};
        vecs[6] = '{a: 6'h07, b: 6'h38, r: 12'h123};
        vecs[7] = '{a: 6'h38, b: 6'h3F, r: 12'hABC};

        bus.ina       = '0;
        bus.inb       = '0;
        bus.rnd       = '0;
        bus.in_valid  = 1'b0;
        bus.rnd_valid = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state.
        #12;
        check("rst_out_valid", 64'(bus.out_valid), 64'(1'b0));
        check("rst_out", 64'(bus.out), 64'(0));
        check("rst_starve", 64'(starve_cnt), 64'(0));
        check("rst_in_ready", 64'(bus.in_ready), 64'(1'b0));
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        bus.rnd_valid = 1'b1;
        #1;
        check("idle_in_ready", 64'(bus.in_ready), 64'(1'b1));
        check("idle_rnd_ready", 64'(bus.rnd_ready), 64'(1'b0));

        // Back-to-back transfers at full throughput.
        for (int i = 0; i < 8; i++) send(vecs[i]);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("drain_out_valid", 64'(bus.out_valid), 64'(1'b0));
        check("drain_out_hold", 64'(bus.out), 64'(model_out(vecs[7].a, vecs[7].b, vecs[7].r)));

        // Backpressure: result held, no overwrite, then release lands the next one.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send(vecs[3]);
        held = model_out(vecs[3].a, vecs[3].b, vecs[3].r);
        bus.ina      = vecs[6].a;
        bus.inb      = vecs[6].b;
        bus.rnd      = vecs[6].r;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(bus.in_ready), 64'(1'b0));
            check("bp_rnd_ready", 64'(bus.rnd_ready), 64'(1'b0));
            check("bp_out_valid", 64'(bus.out_valid), 64'(1'b1));
            check("bp_out", 64'(bus.out), 64'(held));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(vecs[6]);
        bus.in_valid = 1'b0;
        @(negedge clk);

        // Randomness starvation and counter saturation.
        @(posedge clk);
        #1;
        bus.rnd_valid = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            check("starve_in_ready", 64'(bus.in_ready), 64'(1'b0));
            check("starve_rnd_ready", 64'(bus.rnd_ready), 64'(1'b0));
        end
        @(negedge clk);
        check("starve_cnt_7", 64'(starve_cnt), 64'(16'd7));
        repeat (70000) @(posedge clk);
        @(negedge clk);
        check("starve_cnt_sat", 64'(starve_cnt), 64'(16'hFFFF));
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        bus.rnd_valid = 1'b1;

        // Asynchronous reset while a result is held.
        bus.out_ready = 1'b0;
        send(vecs[4]);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(bus.out_valid), 64'(1'b0));
        check("arst_out", 64'(bus.out), 64'(0));
        check("arst_starve", 64'(starve_cnt), 64'(0));
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        send(vecs[5]);
        bus.in_valid = 1'b0;

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check("sb_drain", 64'(sb.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
